// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for an L1 cache: one access at a time,
// IDLE -> BUSY (LATENCY cycles) -> DONE, with alignment/range error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        D_req,
    input  logic [31:0] D_addr,
    input  logic        D_write,
    input  logic [31:0] D_in,
    input  logic [2:0]  D_type,
    output logic [31:0] D_out,
    output logic        D_wait,
    output logic        D_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt,
    output logic [1:0]  fsm_state
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Handshake: the cache holds D_req and the other D_* inputs stable while
    // D_wait is high; the single cycle with D_wait low after the request is
    // DONE, where D_out/D_err are valid. D_req is ignored in DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [31:0] addr_q, data_q;
    logic        write_q;
    logic [2:0]  type_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          is_byte, is_half, range_err, acc_err, access;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [AW-1:0] word_idx;

    assign fsm_state = state;
    assign word_idx  = addr_q[AW+1:2];
    assign access    = (state == BUSY) && (cnt == 4'd1);

    always_comb begin
        is_byte   = (type_q == 3'b000) || (type_q == 3'b100);
        is_half   = (type_q == 3'b001) || (type_q == 3'b101);
        range_err = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
        acc_err   = range_err || (is_half && addr_q[0]) ||
                    (!is_byte && !is_half && (addr_q[1:0] != 2'b00));
    end

    // Narrow writes arrive right-justified; replicate them across the lanes
    // and let the byte enables pick the target bytes.
    always_comb begin
        be    = 4'b1111;
        wdata = data_q;
        if (is_byte) begin
            be    = 4'b0001 << addr_q[1:0];
            wdata = {4{data_q[7:0]}};
        end else if (is_half) begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata = {2{data_q[15:0]}};
        end
    end

    always_comb begin
        state_next = state;
        D_wait     = 1'b0;
        case (state)
            IDLE: begin
                if (D_req) begin
                    state_next = BUSY;
                    D_wait     = 1'b1;
                end
            end
            BUSY: begin
                D_wait = 1'b1;
                if (cnt == 4'd1) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rst) D_wait = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The array is never reset; an access aborted by reset never writes.
    always_ff @(posedge clk) begin
        if (!rst && access && write_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 4'd0;
            D_out  <= 32'h0;
            D_err  <= 1'b0;
            rd_cnt <= 16'h0;
            wr_cnt <= 16'h0;
        end else begin
            D_err <= access && acc_err;
            if (state == IDLE && D_req) begin
                addr_q  <= D_addr;
                write_q <= D_write;
                data_q  <= D_in;
                type_q  <= D_type;
                cnt     <= 4'(LATENCY);
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !write_q) D_out <= acc_err ? 32'h0 : mem[word_idx];
            rd_cnt <= rd_cnt + 16'(access && !write_q && !acc_err && (rd_cnt != 16'hFFFF));
            wr_cnt <= wr_cnt + 16'(access && write_q && !acc_err && (wr_cnt != 16'hFFFF));
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: driver tasks issue requests and push expected
// {err, D_out} into a queue; a negedge monitor pops and compares at each DONE.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk, rst, D_req, D_write;
    logic [31:0] D_addr, D_in, D_out;
    logic [2:0]  D_type;
    logic        D_wait, D_err;
    logic [15:0] rd_cnt, wr_cnt;
    logic [1:0]  fsm_state;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .D_req(D_req), .D_addr(D_addr), .D_write(D_write),
        .D_in(D_in), .D_type(D_type), .D_out(D_out), .D_wait(D_wait), .D_err(D_err),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] m_dout;
    int          m_rd, m_wr;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_access(input logic [31:0] a, input logic w,
                                         input logic [31:0] d, input logic [2:0] t);
        int          sz;
        logic        err;
        logic [31:0] mask;
        int          sh;
        int          wi;
        case (t)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            default:        sz = 4;
        endcase
        err = ((a >> 2) >= 32'(DEPTH)) || (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        wi  = int'(a[11:2]);
        if (!err && w) begin
            if (sz == 4) begin
                mask = 32'hFFFF_FFFF;
                sh   = 0;
            end else begin
                mask = (32'd1 << (8 * sz)) - 32'd1;
                sh   = (sz == 2) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
            end
            ref_mem[wi] = (ref_mem[wi] & ~(mask << sh)) | ((d & mask) << sh);
        end
        if (!w) m_dout = err ? 32'h0 : ref_mem[wi];
        if (!err) begin
            if (w) begin
                if (m_wr < 65535) m_wr++;
            end else begin
                if (m_rd < 65535) m_rd++;
            end
        end
        exp_q.push_back({err, m_dout});
    endfunction

    // driver tasks: called and returning at posedge+1
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [2:0] t);
        bit done;
        D_req   = 1'b1;
        D_addr  = a;
        D_write = w;
        D_in    = d;
        D_type  = t;
        model_access(a, w, d, t);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!D_wait) done = 1'b1;
        end
        if (!done) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic gap(input int n);
        D_req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor / scoreboard
    int          run = 0;
    logic [32:0] e;
    always @(negedge clk) begin
        if (rst) begin
            run = 0;
        end else if (fsm_state == 2'd2) begin
            check("done_wait_low", 32'(D_wait), 32'd0);
            check("wait_length", 32'(run), 32'(LAT + 1));
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("d_err", 32'(D_err), 32'(e[32]));
                check("d_out", D_out, e[31:0]);
            end
            run = 0;
        end else begin
            check("err_outside_done", 32'(D_err), 32'd0);
            if (D_wait) run++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        w;
        logic [2:0]  t;
        rst = 1'b1; D_req = 1'b1; D_addr = '0; D_write = 1'b0; D_in = '0; D_type = 3'b010;
        m_rd = 0; m_wr = 0; m_dout = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wait", 32'(D_wait), 32'd0);
        check("rst_dout", D_out, 32'h0);
        check("rst_err", 32'(D_err), 32'd0);
        check("rst_rdcnt", 32'(rd_cnt), 32'd0);
        check("rst_wrcnt", 32'(wr_cnt), 32'd0);
        D_req = 1'b0;
        rst = 1'b0;
        gap(1);

        // word write then read back
        issue(32'h10, 1'b1, 32'hDEADBEEF, 3'b010); gap(1);
        issue(32'h10, 1'b0, 32'h0, 3'b010);
        check("basic_rd", D_out, 32'hDEADBEEF);
        gap(1);
        check("basic_wrcnt", 32'(wr_cnt), 32'd1);
        check("basic_rdcnt", 32'(rd_cnt), 32'd1);

        // give every word in the test window a defined value
        for (int i = 0; i < 64; i++) issue(32'(i * 4), 1'b1, $urandom, 3'b010);
        gap(1);

        // byte and half merges into a word
        issue(32'h20, 1'b1, 32'h11223344, 3'b010);
        issue(32'h22, 1'b1, 32'h000000AA, 3'b000);
        issue(32'h20, 1'b1, 32'h00005566, 3'b001);
        issue(32'h20, 1'b0, 32'h0, 3'b010);
        check("merge_rd", D_out, 32'h11AA5566);
        gap(2);

        // out-of-range read and misaligned half write
        issue(32'h1000, 1'b0, 32'h0, 3'b010); gap(1);
        issue(32'h21, 1'b1, 32'h0000FFFF, 3'b001); gap(1);
        issue(32'h20, 1'b0, 32'h0, 3'b010); gap(1);
        check("err_rdcnt", 32'(rd_cnt), 32'(m_rd));
        check("err_wrcnt", 32'(wr_cnt), 32'(m_wr));

        // reset in the second BUSY cycle of a write aborts it
        D_req = 1'b1; D_addr = 32'h30; D_write = 1'b1; D_in = 32'hCAFEF00D; D_type = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy", 32'(D_wait), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_wait", 32'(D_wait), 32'd0);
        D_req = 1'b0;
        rst = 1'b0;
        m_rd = 0; m_wr = 0; m_dout = 32'h0;
        @(posedge clk); #1;
        check("abort_wait_idle", 32'(D_wait), 32'd0);
        check("abort_wrcnt", 32'(wr_cnt), 32'd0);
        check("abort_dout", D_out, 32'h0);
        issue(32'h30, 1'b0, 32'h0, 3'b010); gap(1);

        // back-to-back reads with D_req held high
        for (int i = 0; i < 4; i++) issue(32'h40 + 32'(4 * i), 1'b0, 32'h0, 3'b010);
        gap(1);
        check("b2b_rdcnt", 32'(rd_cnt), 32'(m_rd));

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0)
                a = {30'(1024 + $urandom_range(0, 5000)), 2'(0)};
            else
                a = {30'($urandom_range(0, 63)), ($urandom_range(0, 1) != 0) ? 2'd0 : 2'($urandom_range(0, 3))};
            w = 1'($urandom_range(0, 1));
            t = 3'($urandom_range(0, 7));
            issue(a, w, $urandom, t);
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
        end
        gap(2);
        check("rand_rdcnt", 32'(rd_cnt), 32'(m_rd));
        check("rand_wrcnt", 32'(wr_cnt), 32'(m_wr));

        // read counter saturation
        force dut.rd_cnt = 16'hFFFE;
        repeat (2) begin
            @(posedge clk); #1;
        end
        release dut.rd_cnt;
        m_rd = 65534;
        @(posedge clk); #1;
        check("sat_preset", 32'(rd_cnt), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            issue(32'(4 * i), 1'b0, 32'h0, 3'b010);
            gap(1);
            check("sat_rdcnt", 32'(rd_cnt), 32'(m_rd));
        end
        check("sat_final", 32'(rd_cnt), 32'h0000FFFF);

        gap(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the backing store, addressed by D_addr[11:2].
REQ-002 Parameter LATENCY, default 2, legal range 1..15: number of BUSY cycles per access.
REQ-003 Port clk  in  1: single clock; all state updates on rising edge.
REQ-004 Port rst  in  1: synchronous, active-high reset.
REQ-005 Port D_req  in  1: access request from L1 cache; held high, with the other D_* inputs stable, until D_wait is seen low.
REQ-006 Port D_addr  in  32: byte address.
REQ-007 Port D_write  in  1: 1 = write, 0 = read.
REQ-008 Port D_in  in  32: write data, right-justified for byte and half writes.
REQ-009 Port D_type  in  3: access size; 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; other codes are treated as word.
REQ-010 Port D_out  out  32: read data, valid in the DONE cycle.
REQ-011 Port D_wait  out  1: busy indication to cache.
REQ-012 Port D_err  out  1: one-cycle error pulse in the DONE cycle.
REQ-013 Port rd_cnt  out  16: completed error-free reads, saturating.
REQ-014 Port wr_cnt  out  16: completed error-free writes, saturating.

Function
REQ-015 FSM states SHALL be IDLE, BUSY and DONE.
REQ-016 IDLE with D_req=1: capture addr, write, data and type into registers; load the latency counter with LATENCY; go to BUSY.
REQ-017 BUSY: decrement the counter each cycle; when the counter equals 1, perform the array access and go to DONE.
REQ-018 DONE: go to IDLE unconditionally; D_req is ignored in DONE.
REQ-019 D_wait SHALL be combinational: (IDLE & D_req) | BUSY; it is 0 in DONE and in IDLE without a request.
REQ-020 Total latency: D_wait is high for LATENCY+1 cycles, then low for exactly one DONE cycle.
REQ-021 A request still high in the IDLE cycle after DONE is a new access, back-to-back with no bubble.
REQ-022 Read: D_out is registered with the full 32-bit word at captured addr[11:2]; D_type is ignored for reads, and the cache performs lane extraction and extension.
REQ-023 D_out holds its last value until the next completed read.
REQ-024 Byte write: write D_in[7:0] into lane addr[1:0]; other lanes are unchanged.
REQ-025 Half write: write D_in[15:0] into bytes {addr[1],0} and {addr[1],1}.
REQ-026 Word write: write all 4 bytes.
REQ-027 Error condition: addr[31:2] >= DEPTH_WORDS, OR a half access with addr[0]=1, OR a word access with addr[1:0]!=0.
REQ-028 On error: no array write; read returns D_out=32'h0; D_err=1 in DONE; no counter increment.
REQ-029 rd_cnt and wr_cnt increment in the DONE cycle of an error-free access; each holds at 16'hFFFF.
REQ-030 Input changes while BUSY have no effect, because the captured registers are used.
REQ-031 A write followed immediately by a read to the same address returns the new data.

Reset
REQ-032 rst=1 at a clock edge: state=IDLE, counter=0, D_out=0, D_err=0, rd_cnt=0, wr_cnt=0.
REQ-033 While rst=1, D_wait SHALL be 0 regardless of D_req.
REQ-034 Reset in BUSY aborts the access: no array write, no DONE cycle, no counter change.
REQ-035 Array contents are not cleared by reset.

Verification
REQ-036 Word write addr 0x0000_0010 data 0xDEADBEEF, then word read of 0x10 (LATENCY=2) -> D_wait high for 3 cycles each; read DONE D_out=0xDEADBEEF; wr_cnt=1, rd_cnt=1.
REQ-037 Word 0x11223344 at 0x20, then byte write 0xAA at 0x22 and half write 0x5566 at 0x20 -> read of 0x20 returns 0x11AA5566.
REQ-038 Read of 0x0000_1000 (word 1024) and half write at 0x21 -> D_err=1 for one cycle, D_out=0, memory unchanged, counters unchanged.
REQ-039 Assert rst in the 2nd BUSY cycle of a write of 0xCAFEF00D to 0x30 -> D_wait=0 next cycle, no DONE; a later read of 0x30 returns the old value.
REQ-040 Back-to-back: D_req held high across 4 word reads 0x40..0x4C with LATENCY=1 -> DONE every 3rd cycle with correct data; rd_cnt=4.
REQ-041 Preset rd_cnt to 0xFFFE via 65534 reads (or force), then 3 more reads -> rd_cnt saturates at 0xFFFF.
